// File: rtl/ccm_output_unit.sv
// Capture/compare output unit: registered channel output driven by one of eight
// output modes, reacting to rising edges of the CCRn / CCR0 compare levels on timer ticks.
module ccm_output_unit (
    input  logic       MCLK,
    input  logic       reset,
    input  logic       TimerClock,
    input  logic       wOUT,
    input  logic       EQU0,
    input  logic       EQUn,
    input  logic [2:0] OUTMOD,
    output logic       OUTn
);

    localparam logic [2:0] MODE_OUT          = 3'd0;
    localparam logic [2:0] MODE_SET          = 3'd1;
    localparam logic [2:0] MODE_TOGGLE_RESET = 3'd2;
    localparam logic [2:0] MODE_SET_RESET    = 3'd3;
    localparam logic [2:0] MODE_TOGGLE       = 3'd4;
    localparam logic [2:0] MODE_RESET        = 3'd5;
    localparam logic [2:0] MODE_TOGGLE_SET   = 3'd6;

    logic out_q, out_d;
    logic e_n_q, e_n_d;
    logic e_0_q, e_0_d;
    logic ev_n, ev_0;

    always_comb begin
        ev_n  = TimerClock & EQUn & ~e_n_q;
        ev_0  = TimerClock & EQU0 & ~e_0_q;
        // History follows the compare levels on every tick regardless of OUTMOD,
        // so a mode switch never manufactures an edge.
        e_n_d = TimerClock ? EQUn : e_n_q;
        e_0_d = TimerClock ? EQU0 : e_0_q;

        out_d = out_q;
        // ev0 is applied after evN so it takes priority when both fire together.
        case (OUTMOD)
            MODE_OUT: out_d = wOUT;
            MODE_SET: begin
                if (ev_n) out_d = 1'b1;
            end
            MODE_TOGGLE_RESET: begin
                if (ev_n) out_d = ~out_q;
                if (ev_0) out_d = 1'b0;
            end
            MODE_SET_RESET: begin
                if (ev_n) out_d = 1'b1;
                if (ev_0) out_d = 1'b0;
            end
            MODE_TOGGLE: begin
                if (ev_n) out_d = ~out_q;
            end
            MODE_RESET: begin
                if (ev_n) out_d = 1'b0;
            end
            MODE_TOGGLE_SET: begin
                if (ev_n) out_d = ~out_q;
                if (ev_0) out_d = 1'b1;
            end
            default: begin
                if (ev_n) out_d = 1'b0;
                if (ev_0) out_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            out_q <= 1'b0;
            e_n_q <= 1'b0;
            e_0_q <= 1'b0;
        end else begin
            out_q <= out_d;
            e_n_q <= e_n_d;
            e_0_q <= e_0_d;
        end
    end

    assign OUTn = out_q;

endmodule

// File: tb/tb_ccm_output_unit.sv
// Directed self-checking bench for ccm_output_unit; expected values are hand-derived
// from the output-mode definitions.
module tb_ccm_output_unit;

    logic       MCLK;
    logic       reset;
    logic       TimerClock;
    logic       wOUT;
    logic       EQU0;
    logic       EQUn;
    logic [2:0] OUTMOD;
    logic       OUTn;

    int tests_run;
    int tests_failed;

    ccm_output_unit dut (
        .MCLK      (MCLK),
        .reset     (reset),
        .TimerClock(TimerClock),
        .wOUT      (wOUT),
        .EQU0      (EQU0),
        .EQUn      (EQUn),
        .OUTMOD    (OUTMOD),
        .OUTn      (OUTn)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    task automatic step();
        @(posedge MCLK);
        #1;
    endtask

    // Forces OUTn to a known value through mode 0 while a low-compare tick clears history.
    task automatic preset_out(input logic v);
        OUTMOD     = 3'd0;
        wOUT       = v;
        TimerClock = 1'b1;
        EQUn       = 1'b0;
        EQU0       = 1'b0;
        step();
        tests_run++;
        if (OUTn !== v) begin
            tests_failed++;
            $display("FAIL preset_out: OUTn=%b expected=%b", OUTn, v);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        OUTMOD     = 3'd0;
        wOUT       = 1'b1;
        TimerClock = 1'b1;
        EQUn       = 1'b1;
        EQU0       = 1'b1;
        #1;
        tests_run++;
        if (OUTn !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_initial: OUTn=%b expected=0", OUTn);
        end
        step();
        step();
        tests_run++;
        if (OUTn !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_held: OUTn=%b expected=0", OUTn);
        end
        wOUT = 1'b0;
        EQUn = 1'b0;
        EQU0 = 1'b0;
        reset = 1'b0;
        step();
    endtask

    task automatic test_mode0();
        OUTMOD     = 3'd0;
        TimerClock = 1'b0;
        wOUT       = 1'b1;
        #1;
        tests_run++;
        if (OUTn !== 1'b0) begin
            tests_failed++;
            $display("FAIL mode0_no_comb_path: OUTn=%b expected=0", OUTn);
        end
        step();
        tests_run++;
        if (OUTn !== 1'b1) begin
            tests_failed++;
            $display("FAIL mode0_rise: OUTn=%b expected=1", OUTn);
        end
        wOUT = 1'b0;
        step();
        tests_run++;
        if (OUTn !== 1'b0) begin
            tests_failed++;
            $display("FAIL mode0_fall: OUTn=%b expected=0", OUTn);
        end
        // Events ignored in mode 0
        TimerClock = 1'b1;
        EQUn       = 1'b1;
        step();
        tests_run++;
        if (OUTn !== 1'b0) begin
            tests_failed++;
            $display("FAIL mode0_ignores_event: OUTn=%b expected=0", OUTn);
        end
    endtask

    task automatic test_mode4_toggle();
        preset_out(1'b0);
        OUTMOD     = 3'd4;
        TimerClock = 1'b1;
        EQUn       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (OUTn !== 1'b1) begin
                tests_failed++;
                $display("FAIL mode4_held_tick%0d: OUTn=%b expected=1", i, OUTn);
            end
        end
        EQUn = 1'b0;
        step();
        EQUn = 1'b1;
        step();
        tests_run++;
        if (OUTn !== 1'b0) begin
            tests_failed++;
            $display("FAIL mode4_second_pulse: OUTn=%b expected=0", OUTn);
        end
        // ev0 has no effect in mode 4
        EQUn = 1'b0;
        EQU0 = 1'b1;
        step();
        tests_run++;
        if (OUTn !== 1'b0) begin
            tests_failed++;
            $display("FAIL mode4_ev0_ignored: OUTn=%b expected=0", OUTn);
        end
        EQU0 = 1'b0;
        step();
    endtask

    task automatic test_mode7_pwm();
        logic exp;
        preset_out(1'b1);
        exp        = 1'b1;
        OUTMOD     = 3'd7;
        TimerClock = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            EQUn = ((t % 20) == 10) ? 1'b1 : 1'b0;
            EQU0 = ((t % 20) == 0)  ? 1'b1 : 1'b0;
            step();
            if ((t % 20) == 10) exp = 1'b0;
            else if ((t % 20) == 0) exp = 1'b1;
            tests_run++;
            if (OUTn !== exp) begin
                tests_failed++;
                $display("FAIL mode7_pwm_t%0d: OUTn=%b expected=%b", t, OUTn, exp);
            end
        end
        EQUn = 1'b0;
        EQU0 = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [2:0] modes [5] = '{3'd2, 3'd2, 3'd6, 3'd3, 3'd7};
        logic       start [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       want  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            preset_out(start[i]);
            OUTMOD = modes[i];
            EQUn   = 1'b1;
            EQU0   = 1'b1;
            step();
            tests_run++;
            if (OUTn !== want[i]) begin
                tests_failed++;
                $display("FAIL simultaneous_mode%0d_from%b: OUTn=%b expected=%b",
                         modes[i], start[i], OUTn, want[i]);
            end
        end
    endtask

    task automatic test_no_tick();
        preset_out(1'b0);
        OUTMOD     = 3'd1;
        EQUn       = 1'b1;
        TimerClock = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            tests_run++;
            if (OUTn !== 1'b0) begin
                tests_failed++;
                $display("FAIL no_tick_cycle%0d: OUTn=%b expected=0", i, OUTn);
            end
        end
        TimerClock = 1'b1;
        step();
        tests_run++;
        if (OUTn !== 1'b1) begin
            tests_failed++;
            $display("FAIL no_tick_first_tick: OUTn=%b expected=1", OUTn);
        end
    endtask

    task automatic test_mode_change();
        // OUTn=1 and EQUn still held high from the previous test: no new edge exists.
        OUTMOD = 3'd5;
        step();
        tests_run++;
        if (OUTn !== 1'b1) begin
            tests_failed++;
            $display("FAIL mode_change_no_spurious: OUTn=%b expected=1", OUTn);
        end
        EQUn = 1'b0;
        step();
        EQUn = 1'b1;
        step();
        tests_run++;
        if (OUTn !== 1'b0) begin
            tests_failed++;
            $display("FAIL mode5_reset: OUTn=%b expected=0", OUTn);
        end
        EQUn = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        preset_out(1'b0);
        OUTMOD = 3'd3;
        EQUn   = 1'b1;
        step();
        tests_run++;
        if (OUTn !== 1'b1) begin
            tests_failed++;
            $display("FAIL mode3_set: OUTn=%b expected=1", OUTn);
        end
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (OUTn !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_async: OUTn=%b expected=0", OUTn);
        end
        step();
        reset = 1'b0;
        tests_run++;
        if (OUTn !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_held: OUTn=%b expected=0", OUTn);
        end
        step();
        tests_run++;
        if (OUTn !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_event: OUTn=%b expected=1", OUTn);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        TimerClock   = 1'b0;
        wOUT         = 1'b0;
        EQU0         = 1'b0;
        EQUn         = 1'b0;
        OUTMOD       = 3'd0;

        test_reset();
        test_mode0();
        test_mode4_toggle();
        test_mode7_pwm();
        test_simultaneous();
        test_no_tick();
        test_mode_change();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
